param_register_file: RTL and testbench

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_cell.sv | 58 +++++
 rtl/param_register_file.sv | 61 ++++++
 tb/tb_param_register_file.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared operation encodings for the register file and the ALU-side control logic.
package regfile_pkg;

    localparam logic [2:0] FUN_DEC     = 3'b000;
    localparam logic [2:0] FUN_INC     = 3'b001;
    localparam logic [2:0] FUN_LOAD    = 3'b010;
    localparam logic [2:0] FUN_CLEAR   = 3'b011;
    localparam logic [2:0] FUN_LOADL_Z = 3'b100;
    localparam logic [2:0] FUN_LOADL_K = 3'b101;
    localparam logic [2:0] FUN_LOADH_K = 3'b110;
    localparam logic [2:0] FUN_LOADL_S = 3'b111;

endpackage

// File: rtl/reg_cell.sv
// One register of the file: applies the shared operation when enabled and
// exposes its next-state value and wrap condition for the top level.
module reg_cell
    import regfile_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             E,
    input  logic [2:0]       FunSel,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] D,
    output logic             wrap
);

    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_op;
    logic             w_wrap;

    always_comb begin
        w_op = r_q;
        unique case (FunSel)
            FUN_DEC:     w_op = r_q - ONE;
            FUN_INC:     w_op = r_q + ONE;
            FUN_LOAD:    w_op = I;
            FUN_CLEAR:   w_op = '0;
            FUN_LOADL_Z: w_op = {{H{1'b0}}, I[H-1:0]};
            FUN_LOADL_K: w_op = {r_q[WIDTH-1:H], I[H-1:0]};
            FUN_LOADH_K: w_op = {I[H-1:0], r_q[H-1:0]};
            FUN_LOADL_S: w_op = {{H{I[H-1]}}, I[H-1:0]};
            default:     w_op = r_q;
        endcase
    end

    // A wrap only counts when the operation actually commits, so reset masks it.
    assign w_wrap = E && (((FunSel == FUN_INC) && (&r_q)) ||
                          ((FunSel == FUN_DEC) && (r_q == '0)));
    assign wrap   = Reset && w_wrap;

    // Next-state view includes reset so bypassed reads show 0 in the reset cycle.
    assign D = !Reset ? '0 : (E ? w_op : r_q);

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_q <= '0;
        end else if (E) begin
            r_q <= w_op;
        end
    end

    assign Q = r_q;

endmodule

// File: rtl/param_register_file.sv
// Parameterised register file: per-register active-low enables, two independent
// read ports with optional write-through forwarding, and a registered wrap flag.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int BYPASS   = 0
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic [WIDTH-1:0]            I,
    input  logic [2:0]                  FunSel,
    input  logic [NUM_REGS-1:0]         RegSel,
    input  logic [$clog2(NUM_REGS)-1:0] OutASel,
    input  logic [$clog2(NUM_REGS)-1:0] OutBSel,
    output logic [WIDTH-1:0]            OutA,
    output logic [WIDTH-1:0]            OutB,
    output logic                        Ovf
);

    logic [WIDTH-1:0]    w_q [NUM_REGS];
    logic [WIDTH-1:0]    w_d [NUM_REGS];
    logic [NUM_REGS-1:0] w_wrap;
    logic                r_ovf;

    // RegSel is MSB-first: register k is enabled by bit NUM_REGS-1-k being low.
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
        reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .Clock  (Clock),
            .Reset  (Reset),
            .E      (~RegSel[NUM_REGS-1-k]),
            .FunSel (FunSel),
            .I      (I),
            .Q      (w_q[k]),
            .D      (w_d[k]),
            .wrap   (w_wrap[k])
        );
    end

    if (BYPASS != 0) begin : g_bypass
        assign OutA = w_d[OutASel];
        assign OutB = w_d[OutBSel];
    end else begin : g_stored
        assign OutA = w_q[OutASel];
        assign OutB = w_q[OutBSel];
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= |w_wrap;
        end
    end

    assign Ovf = r_ovf;

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: one stored-read and one bypass
// instance driven by the same stimulus, checked against hand-computed values.
module tb_param_register_file;
    import regfile_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] I;
    logic [2:0]  FunSel;
    logic [7:0]  RegSel;
    logic [2:0]  OutASel;
    logic [2:0]  OutBSel;
    logic [15:0] outA0, outB0, outA1, outB1;
    logic        ovf0, ovf1;

    int assertCount = 0;
    int failCount   = 0;

    always #20 Clock = ~Clock;

    param_register_file #(.WIDTH(16), .NUM_REGS(8), .BYPASS(0)) dut0 (
        .Clock (Clock), .Reset (Reset), .I (I), .FunSel (FunSel), .RegSel (RegSel),
        .OutASel (OutASel), .OutBSel (OutBSel), .OutA (outA0), .OutB (outB0), .Ovf (ovf0)
    );

    param_register_file #(.WIDTH(16), .NUM_REGS(8), .BYPASS(1)) dut1 (
        .Clock (Clock), .Reset (Reset), .I (I), .FunSel (FunSel), .RegSel (RegSel),
        .OutASel (OutASel), .OutBSel (OutBSel), .OutA (outA1), .OutB (outB1), .Ovf (ovf1)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge so they are stable well before the rising edge.
    task automatic setInputs(input logic rst, input logic [7:0] sel,
                             input logic [2:0] fs, input logic [15:0] data);
        @(negedge Clock);
        Reset  = rst;
        RegSel = sel;
        FunSel = fs;
        I      = data;
    endtask

    task automatic applyStimulus(input logic rst, input logic [7:0] sel,
                                 input logic [2:0] fs, input logic [15:0] data);
        setInputs(rst, sel, fs, data);
        @(posedge Clock);
        #1;
    endtask

    task automatic checkReg(input string tag, input int idx, input logic [15:0] expected);
        OutASel = 3'(idx);
        OutBSel = 3'(idx);
        #1;
        checkOutput($sformatf("%s r%0d A", tag, idx), outA0, expected);
        checkOutput($sformatf("%s r%0d B", tag, idx), outB0, expected);
    endtask

    task automatic checkAll(input string tag, input logic [15:0] expected, input bit withBypass);
        for (int i = 0; i < 8; i++) begin
            OutASel = 3'(i);
            OutBSel = 3'(7 - i);
            #1;
            checkOutput($sformatf("%s A r%0d", tag, i), outA0, expected);
            checkOutput($sformatf("%s B r%0d", tag, 7 - i), outB0, expected);
            if (withBypass) begin
                checkOutput($sformatf("%s byp A r%0d", tag, i), outA1, expected);
            end
        end
    endtask

    task automatic checkOvf(input string tag, input logic expected);
        checkOutput({tag, " ovf"}, {15'b0, ovf0}, {15'b0, expected});
        checkOutput({tag, " ovf byp"}, {15'b0, ovf1}, {15'b0, expected});
    endtask

    initial begin
        Reset = 1'b0; RegSel = 8'hFF; FunSel = FUN_LOAD; I = 16'h0;
        OutASel = 3'd0; OutBSel = 3'd0;

        // Reset with every register enabled for LOAD: reset must win.
        applyStimulus(1'b0, 8'h00, FUN_LOAD, 16'h1111);
        checkAll("reset", 16'h0000, 1'b1);
        checkOvf("reset", 1'b0);

        applyStimulus(1'b1, 8'h00, FUN_LOAD, 16'hFFFF);
        checkReg("loadall", 5, 16'hFFFF);
        checkOvf("loadall", 1'b0);

        applyStimulus(1'b1, 8'h00, FUN_INC, 16'h0000);
        checkReg("incwrap", 0, 16'h0000);
        checkReg("incwrap", 7, 16'h0000);
        checkOvf("incwrap", 1'b1);

        applyStimulus(1'b1, 8'h00, FUN_LOAD, 16'hC3C3);
        checkReg("reload", 6, 16'hC3C3);
        checkOvf("reload", 1'b0);

        applyStimulus(1'b1, 8'h00, FUN_INC, 16'h0000);
        applyStimulus(1'b0, 8'h00, FUN_LOAD, 16'h7777);
        checkAll("rst+load", 16'h0000, 1'b0);
        checkOvf("rst+load", 1'b0);

        // Single-register wrap on register 3 (RegSel bit 4).
        applyStimulus(1'b1, 8'b11101111, FUN_LOAD, 16'hFFFF);
        checkReg("r3load", 3, 16'hFFFF);
        checkReg("r3load", 2, 16'h0000);
        checkOvf("r3load", 1'b0);
        applyStimulus(1'b1, 8'b11101111, FUN_INC, 16'h0000);
        checkReg("r3inc", 3, 16'h0000);
        checkOvf("r3inc", 1'b1);
        applyStimulus(1'b1, 8'b11101111, FUN_LOAD, 16'h0042);
        checkReg("r3next", 3, 16'h0042);
        checkOvf("r3next", 1'b0);

        applyStimulus(1'b1, 8'b11110111, FUN_DEC, 16'h0000);
        checkReg("r4dec", 4, 16'hFFFF);
        checkOvf("r4dec", 1'b1);
        applyStimulus(1'b1, 8'hFF, FUN_INC, 16'h0000);
        checkReg("hold", 4, 16'hFFFF);
        checkReg("hold", 3, 16'h0042);
        checkOvf("hold", 1'b0);

        // Half-word operations on register 0 (RegSel bit 7).
        applyStimulus(1'b1, 8'b01111111, FUN_LOAD, 16'h1234);
        checkReg("r0load", 0, 16'h1234);
        applyStimulus(1'b1, 8'b01111111, FUN_LOADH_K, 16'h00AB);
        checkReg("loadh_k", 0, 16'hAB34);
        applyStimulus(1'b1, 8'b01111111, FUN_LOADL_K, 16'h0011);
        checkReg("loadl_k", 0, 16'hAB11);
        applyStimulus(1'b1, 8'b01111111, FUN_LOADL_S, 16'h0080);
        checkReg("loadl_s", 0, 16'hFF80);
        applyStimulus(1'b1, 8'b01111111, FUN_LOADL_Z, 16'hFF7F);
        checkReg("loadl_z", 0, 16'h007F);
        checkOvf("loadl_z", 1'b0);

        applyStimulus(1'b1, 8'h00, FUN_CLEAR, 16'hFFFF);
        checkAll("clear", 16'h0000, 1'b0);
        applyStimulus(1'b1, 8'h00, FUN_INC, 16'h0000);
        applyStimulus(1'b1, 8'h00, FUN_INC, 16'h0000);
        applyStimulus(1'b1, 8'h00, FUN_INC, 16'h0000);
        checkOvf("inc3", 1'b0);
        applyStimulus(1'b1, 8'hFF, FUN_INC, 16'h0000);
        checkAll("inc3", 16'h0003, 1'b1);
        checkReg("same5", 5, 16'h0003);

        // Forwarding: register 2 (RegSel bit 5) loaded while port A reads it.
        setInputs(1'b1, 8'b11011111, FUN_LOAD, 16'h5A5A);
        OutASel = 3'd2;
        OutBSel = 3'd3;
        #1;
        checkOutput("fwd pre A", outA0, 16'h0003);
        checkOutput("fwd pre byp A", outA1, 16'h5A5A);
        checkOutput("fwd pre byp B", outB1, 16'h0003);
        @(posedge Clock);
        #1;
        checkOutput("fwd post A", outA0, 16'h5A5A);

        setInputs(1'b0, 8'hFF, FUN_LOAD, 16'h1111);
        #1;
        checkOutput("rstcyc A", outA0, 16'h5A5A);
        checkOutput("rstcyc byp A", outA1, 16'h0000);
        @(posedge Clock);
        #1;
        checkOutput("rstpost A", outA0, 16'h0000);
        checkOvf("rstpost", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
